// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore table and restore stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hiscore_pkg;

    // Per-entry table field widths, common to the address-table stage.
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 8;
    localparam int MARK_W = 8;

    // ioctl_index carrying score data unless overridden.
    localparam logic [7:0] DATA_INDEX_DEF = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        CHK_FETCH,
        CHK_START,
        CHK_END,
        RETRY,
        WR_FETCH,
        WR_BYTE,
        DONE
    } state_t;

endpackage

// File: rtl/dpram_dc.sv
// Dual-port RAM: port A write-only, port B registered read.
// Latency: write lands 1 cycle after we_a; q_b valid 1 cycle after addr_b.
// Backpressure: none, both ports accept every cycle.
//
// Ports: clk_a/we_a/addr_a/data_a write side; clk_b/addr_b/q_b read side.
module dpram_dc #(
    parameter int addr_width_g = 8,
    parameter int data_width_g = 8
) (
    input  logic                    clk_a,
    input  logic                    we_a,
    input  logic [addr_width_g-1:0] addr_a,
    input  logic [data_width_g-1:0] data_a,
    input  logic                    clk_b,
    input  logic [addr_width_g-1:0] addr_b,
    output logic [data_width_g-1:0] q_b
);

    logic [data_width_g-1:0] mem [0:(2**addr_width_g)-1];

    always_ff @(posedge clk_a) begin
        if (we_a) begin
            mem[addr_a] <= data_a;
        end
    end

    always_ff @(posedge clk_b) begin
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/hiscore_restore.sv
// Restores a downloaded high-score blob into game RAM once both entry markers are seen.
// Latency: busy 1 cycle after download falls; 1 fetch + 2x2 compare cycles per entry; then 1 byte/clk.
// Backpressure: writes stall while vblank=0; marker mismatch waits RETRY_CYCLES and rechecks.
//
// Ports: ioctl_* capture stream; num_entries/tbl_* entry table (1-cycle read);
//        ram_* game RAM (1-cycle read); busy/done/short_o status.
module hiscore_restore
    import hiscore_pkg::*;
#(
    parameter logic [7:0] DATA_INDEX   = DATA_INDEX_DEF,
    parameter int         TABLE_AW     = 4,
    parameter int         BUF_AW       = 8,
    parameter int         RAM_AW       = 10,
    parameter int         RETRY_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    input  logic [TABLE_AW:0]   num_entries,
    output logic [TABLE_AW-1:0] tbl_idx,
    input  logic [ADDR_W-1:0]   tbl_addr,
    input  logic [LEN_W-1:0]    tbl_len,
    input  logic [MARK_W-1:0]   tbl_start,
    input  logic [MARK_W-1:0]   tbl_end,
    input  logic                vblank,
    output logic [RAM_AW-1:0]   ram_addr,
    input  logic [7:0]          ram_rdata,
    output logic [7:0]          ram_wdata,
    output logic                ram_we,
    output logic                busy,
    output logic                done,
    output logic                short_o
);

    localparam int CNT_W = BUF_AW + 1;
    localparam int IDX_W = TABLE_AW + 1;
    localparam int RET_W = $clog2(RETRY_CYCLES + 1);

    state_t             state, state_nxt;
    logic               phase, phase_nxt;       // 0: request issued, 1: read data valid
    logic [IDX_W-1:0]   idx, idx_nxt;           // one extra bit so idx can equal 2^TABLE_AW
    logic [LEN_W-1:0]   offset, offset_nxt;
    logic [CNT_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   rx_count, rx_count_nxt, rx_base, wr_count;
    logic [RET_W-1:0]   retry_cnt, retry_nxt;
    logic               short_q, short_nxt;
    logic               data_dl, data_dl_q, cap_start, cap_we, trigger;
    logic               idx_at_end, ent_last, len_last;
    logic [ADDR_W-1:0]  sum_wr, sum_end, ram_addr_full;
    logic               ram_we_c;
    logic [7:0]         buf_q;
    logic               unused_addr_bits;

    // ---------------- capture ----------------
    assign data_dl   = ioctl_download && (ioctl_index == DATA_INDEX);
    assign cap_start = data_dl && !data_dl_q;
    assign cap_we    = data_dl && ioctl_wr;
    assign trigger   = data_dl_q && !ioctl_download && (rx_count != '0);

    always_comb begin
        if (|ioctl_addr[24:BUF_AW]) begin
            wr_count = {1'b1, {BUF_AW{1'b0}}};
        end else begin
            wr_count = {1'b0, ioctl_addr[BUF_AW-1:0]} + CNT_W'(1);
        end
        // A fresh capture counts from zero even if a byte arrives in its first cycle.
        rx_base      = cap_start ? '0 : rx_count;
        rx_count_nxt = rx_base;
        if (cap_we && (wr_count > rx_base)) begin
            rx_count_nxt = wr_count;
        end
    end

    // Port B address follows ptr_nxt so buf_q always equals buf[ptr].
    dpram_dc #(
        .addr_width_g (BUF_AW),
        .data_width_g (8)
    ) u_buf (
        .clk_a  (clk),
        .we_a   (cap_we),
        .addr_a (ioctl_addr[BUF_AW-1:0]),
        .data_a (ioctl_dout),
        .clk_b  (clk),
        .addr_b (ptr_nxt[BUF_AW-1:0]),
        .q_b    (buf_q)
    );

    // ---------------- restore FSM ----------------
    assign idx_at_end = (idx == num_entries);
    assign ent_last   = ((idx + IDX_W'(1)) == num_entries);
    assign len_last   = (offset == (tbl_len - LEN_W'(1)));
    assign sum_wr     = tbl_addr + ADDR_W'(offset);
    assign sum_end    = tbl_addr + ADDR_W'(tbl_len) - ADDR_W'(1);

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        idx_nxt       = idx;
        offset_nxt    = offset;
        ptr_nxt       = ptr;
        retry_nxt     = retry_cnt;
        short_nxt     = short_q;
        ram_we_c      = 1'b0;
        ram_addr_full = '0;

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = CHK_FETCH;
                    idx_nxt   = '0;
                    ptr_nxt   = '0;
                    phase_nxt = 1'b0;
                end
            end
            CHK_FETCH: begin
                phase_nxt = 1'b0;
                if (idx_at_end) begin
                    idx_nxt   = '0;
                    state_nxt = WR_FETCH;
                end else begin
                    state_nxt = CHK_START;
                end
            end
            CHK_START: begin
                if (tbl_len == '0) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = CHK_FETCH;
                end else begin
                    ram_addr_full = tbl_addr;
                    if (!phase) begin
                        phase_nxt = 1'b1;
                    end else if (ram_rdata == tbl_start) begin
                        phase_nxt = 1'b0;
                        state_nxt = CHK_END;
                    end else begin
                        retry_nxt = '0;
                        state_nxt = RETRY;
                    end
                end
            end
            CHK_END: begin
                ram_addr_full = sum_end;
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else if (ram_rdata == tbl_end) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = CHK_FETCH;
                end else begin
                    retry_nxt = '0;
                    state_nxt = RETRY;
                end
            end
            RETRY: begin
                if (retry_cnt == RET_W'(RETRY_CYCLES - 1)) begin
                    idx_nxt   = '0;
                    state_nxt = CHK_FETCH;
                end else begin
                    retry_nxt = retry_cnt + RET_W'(1);
                end
            end
            WR_FETCH: begin
                if (!phase) begin
                    if (idx_at_end) begin
                        state_nxt = DONE;
                    end else begin
                        phase_nxt = 1'b1;
                    end
                end else if (tbl_len == '0) begin
                    idx_nxt   = idx + IDX_W'(1);
                    phase_nxt = 1'b0;
                end else begin
                    offset_nxt = '0;
                    state_nxt  = WR_BYTE;
                end
            end
            WR_BYTE: begin
                if (ptr == rx_count) begin
                    // Entered a new entry with no buffered data left.
                    short_nxt = 1'b1;
                    state_nxt = DONE;
                end else if (vblank) begin
                    ram_we_c      = 1'b1;
                    ram_addr_full = sum_wr;
                    ptr_nxt       = ptr + CNT_W'(1);
                    offset_nxt    = offset + LEN_W'(1);
                    if (len_last) begin
                        // Finishing the final entry goes straight to DONE so done
                        // rises the cycle after this write.
                        if (ent_last) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = idx + IDX_W'(1);
                            phase_nxt = 1'b0;
                            state_nxt = WR_FETCH;
                        end
                    end else if ((ptr + CNT_W'(1)) == rx_count) begin
                        short_nxt = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
            end
            default: state_nxt = IDLE;
        endcase

        // A new data download abandons whatever was in flight.
        if (cap_start) begin
            state_nxt     = IDLE;
            short_nxt     = 1'b0;
            ram_we_c      = 1'b0;
            ram_addr_full = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            idx       <= '0;
            offset    <= '0;
            ptr       <= '0;
            retry_cnt <= '0;
            short_q   <= 1'b0;
            rx_count  <= '0;
            data_dl_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            idx       <= idx_nxt;
            offset    <= offset_nxt;
            ptr       <= ptr_nxt;
            retry_cnt <= retry_nxt;
            short_q   <= short_nxt;
            rx_count  <= rx_count_nxt;
            data_dl_q <= data_dl;
        end
    end

    // Address arithmetic is 24-bit; only the low RAM_AW bits reach the RAM.
    assign unused_addr_bits = ^ram_addr_full[ADDR_W-1:RAM_AW];

    assign tbl_idx   = idx[TABLE_AW-1:0];
    assign ram_addr  = ram_addr_full[RAM_AW-1:0];
    assign ram_we    = ram_we_c;
    assign ram_wdata = ram_we_c ? buf_q : 8'h00;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign short_o   = short_q;

endmodule

// File: tb/tb_hiscore_restore.sv
// Scoreboard bench for hiscore_restore: expected RAM writes queued by stimulus, popped by monitor.
// Latency: models 1-cycle table and RAM reads.
// Backpressure: vblank held high or toggled every 5 cycles.
module tb_hiscore_restore;

    localparam int RETRY = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [4:0]  num_entries = 5'd1;
    logic [3:0]  tbl_idx;
    logic [23:0] tbl_addr;
    logic [7:0]  tbl_len, tbl_start, tbl_end;
    logic        vblank;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_rdata, ram_wdata;
    logic        ram_we, busy, done, short_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nwr = 0;
    int last_we_cyc = 0;
    bit saw_we = 0;
    bit done_prev = 0;
    bit vb_mode = 0;

    // Table and game RAM models.
    logic [23:0] t_addr  [16];
    logic [7:0]  t_len   [16];
    logic [7:0]  t_start [16];
    logic [7:0]  t_end   [16];
    logic [7:0]  ram     [1024];
    logic [7:0]  shadow  [256];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [7:0]  poke_val = '0;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    hiscore_restore #(.RETRY_CYCLES(RETRY)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .num_entries    (num_entries),
        .tbl_idx        (tbl_idx),
        .tbl_addr       (tbl_addr),
        .tbl_len        (tbl_len),
        .tbl_start      (tbl_start),
        .tbl_end        (tbl_end),
        .vblank         (vblank),
        .ram_addr       (ram_addr),
        .ram_rdata      (ram_rdata),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .busy           (busy),
        .done           (done),
        .short_o        (short_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        tbl_addr  <= t_addr[tbl_idx];
        tbl_len   <= t_len[tbl_idx];
        tbl_start <= t_start[tbl_idx];
        tbl_end   <= t_end[tbl_idx];
        ram_rdata <= ram[ram_addr];
        if (poke_en) ram[poke_addr] <= poke_val;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // vblank: held high, or toggled every 5 cycles when vb_mode is set.
    initial begin
        int vb_cnt = 0;
        vblank = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!vb_mode) begin
                vblank = 1'b1;
                vb_cnt = 0;
            end else begin
                vb_cnt++;
                if (vb_cnt == 5) begin
                    vb_cnt = 0;
                    vblank = !vblank;
                end
            end
        end
    end

    // Monitor: every RAM write must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                nwr++;
                chk("we_in_vblank", {31'd0, vblank}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {22'd0, ram_addr}, {22'd0, e.a});
                    chk("wr_data", {24'd0, ram_wdata}, {24'd0, e.d});
                end
                last_we_cyc = cyc;
                saw_we = 1;
            end
            if (done && !done_prev && saw_we) begin
                chk("done_after_last_we", cyc - last_we_cyc, 1);
                saw_we = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic poke(input int a, input logic [7:0] v);
        poke_addr = 10'(a);
        poke_val  = v;
        poke_en   = 1'b1;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    task automatic download(input logic [7:0] idx, input int first, input int n, input logic [7:0] seed);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(first + i);
            ioctl_dout = seed + 8'(i * 7);
            if (idx == 8'h04) shadow[first + i] = ioctl_dout;
            @(posedge clk); #1;
        end
        ioctl_wr = 1'b0;
        @(posedge clk); #1;
        ioctl_download = 1'b0;
    endtask

    task automatic push_entry(input int base, input int len, input int bstart);
        wr_t w;
        for (int i = 0; i < len; i++) begin
            w.a = 10'(base + i);
            w.d = shadow[bstart + i];
            exp_q.push_back(w);
        end
    endtask

    task automatic busy_rise(input string name);
        @(negedge clk);
        chk({name, "_busy_before"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic set_markers();
        poke(32'h0B, 8'h01);
        poke(32'h1A, 8'h00);
        poke(32'h23, 8'hA5);
        poke(32'h31, 8'h5A);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 16; i++) begin
            t_addr[i] = '0; t_len[i] = '0; t_start[i] = '0; t_end[i] = '0;
        end
        t_addr[0] = 24'h00000B; t_len[0] = 8'd16; t_start[0] = 8'h01; t_end[0] = 8'h00;
        t_addr[1] = 24'h000023; t_len[1] = 8'd15; t_start[1] = 8'hA5; t_end[1] = 8'h5A;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
        chk("rst_ram_addr",  {22'd0, ram_addr},  32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_tbl_idx",   {28'd0, tbl_idx},   32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_short",     {31'd0, short_o},   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: single entry, 16 bytes, vblank high.
        num_entries = 5'd1;
        set_markers();
        n0 = nwr;
        download(8'h04, 0, 16, 8'h11);
        push_entry(32'h0B, 16, 0);
        busy_rise("t1");
        wait_done("t1", 300);
        chk("t1_short", {31'd0, short_o}, 32'd0);
        chk("t1_writes", nwr - n0, 16);
        chk("t1_queue_left", exp_q.size(), 0);

        // T6: non-data download leaves buffer, FSM and done alone.
        download(8'h01, 0, 16, 8'h90);
        repeat (20) @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done_sticky", {31'd0, done}, 32'd1);
        // Only byte 15 rewritten: bytes 0..14 must still be the T1 data.
        set_markers();
        n0 = nwr;
        download(8'h04, 15, 1, 8'hC3);
        chk("t6_done_cleared", {31'd0, done}, 32'd0);
        push_entry(32'h0B, 16, 0);
        busy_rise("t6");
        wait_done("t6", 300);
        chk("t6_writes", nwr - n0, 16);

        // T2: end marker wrong, retry until it appears.
        poke(32'h0B, 8'h01);
        poke(32'h1A, 8'h55);
        n0 = nwr;
        download(8'h04, 0, 16, 8'h20);
        busy_rise("t2");
        repeat (3 * RETRY) @(negedge clk);
        chk("t2_no_writes", nwr - n0, 0);
        chk("t2_still_busy", {31'd0, busy}, 32'd1);
        chk("t2_not_done", {31'd0, done}, 32'd0);
        push_entry(32'h0B, 16, 0);
        poke(32'h1A, 8'h00);
        wait_done("t2", 3 * RETRY);
        chk("t2_writes", nwr - n0, 16);
        chk("t2_short", {31'd0, short_o}, 32'd0);

        // T3: two entries, vblank toggling.
        num_entries = 5'd2;
        set_markers();
        n0 = nwr;
        vb_mode = 1;
        download(8'h04, 0, 31, 8'h40);
        push_entry(32'h0B, 16, 0);
        push_entry(32'h23, 15, 16);
        wait_done("t3", 500);
        vb_mode = 0;
        chk("t3_writes", nwr - n0, 31);
        chk("t3_short", {31'd0, short_o}, 32'd0);
        chk("t3_queue_left", exp_q.size(), 0);

        // T4: short download.
        set_markers();
        n0 = nwr;
        download(8'h04, 0, 20, 8'h60);
        push_entry(32'h0B, 16, 0);
        push_entry(32'h23, 4, 16);
        wait_done("t4", 300);
        chk("t4_writes", nwr - n0, 20);
        chk("t4_short", {31'd0, short_o}, 32'd1);
        chk("t4_queue_left", exp_q.size(), 0);

        // T5: reset in the middle of the write burst.
        set_markers();
        n0 = nwr;
        download(8'h04, 0, 31, 8'h80);
        push_entry(32'h0B, 16, 0);
        push_entry(32'h23, 15, 16);
        for (int i = 0; i < 300 && (nwr - n0) < 5; i++) @(negedge clk);
        chk("t5_writes_started", {31'd0, ((nwr - n0) >= 5)}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_ram_we",    {31'd0, ram_we},    32'd0);
        chk("t5_ram_addr",  {22'd0, ram_addr},  32'd0);
        chk("t5_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("t5_tbl_idx",   {28'd0, tbl_idx},   32'd0);
        chk("t5_busy",      {31'd0, busy},      32'd0);
        chk("t5_done",      {31'd0, done},      32'd0);
        chk("t5_short",     {31'd0, short_o},   32'd0);
        chk("t5_partial", {31'd0, ((nwr - n0) < 31)}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
